// File: rtl/csp_mux_n.sv
// csp_mux_n: N-way valid/ready channel mux, select-steered or round-robin,
// decoupled from the output port by a small FIFO that tags each token's source.
module csp_mux_n #(
    parameter int WIDTH  = 11,
    parameter int NUM_IN = 2,
    parameter int SEL_W  = 1,
    parameter int DEPTH  = 2,
    parameter int MODE   = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_IN*WIDTH-1:0]   in_data,
    input  logic [NUM_IN-1:0]         in_valid,
    output logic [NUM_IN-1:0]         in_ready,
    input  logic [SEL_W-1:0]          sel_data,
    input  logic                      sel_valid,
    output logic                      sel_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_src,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      sel_err,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [SEL_W-1:0] mem_s [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_nx;
    logic [CW-1:0]    cnt_left;
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] gidx;
    logic [WIDTH-1:0] wtok;
    logic             full;
    logic             grant;
    logic             pop;
    logic             sel_hit;
    logic             sel_bad;
    logic             found;

    assign full = (count == CW'(DEPTH));
    assign pop  = out_valid && out_ready;

    always_comb begin
        sel_hit = 1'b0;
        sel_bad = 1'b1;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel_data == SEL_W'(i)) begin
                sel_bad = 1'b0;
                sel_hit = in_valid[i];
            end
        end
    end

    // Round-robin search starts at rr_ptr and wraps; first valid wins.
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        grant = 1'b0;
        if (MODE == 0) begin
            gidx  = sel_data;
            grant = reset && sel_valid && sel_hit && !full;
        end else begin
            for (int k = 0; k < NUM_IN; k++) begin
                for (int j = 0; j < NUM_IN; j++) begin
                    if (!found && in_valid[j] &&
                        j == (int'(rr_ptr) + k) % NUM_IN) begin
                        found = 1'b1;
                        gidx  = SEL_W'(j);
                    end
                end
            end
            grant = reset && found && !full;
        end
    end

    always_comb begin
        wtok     = '0;
        in_ready = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (gidx == SEL_W'(i)) begin
                wtok        = in_data[i*WIDTH +: WIDTH];
                in_ready[i] = grant;
            end
        end
    end

    // Out-of-range selects are dropped without waiting on FIFO space.
    assign sel_ready = (MODE == 0) && reset && sel_valid &&
                       (sel_bad || (sel_hit && !full));

    assign rd_nx    = rd_ptr + AW'(pop);
    assign cnt_left = count - CW'(pop);

    always_ff @(posedge clk) begin
        if (grant) begin
            mem_d[wr_ptr] <= wtok;
            mem_s[wr_ptr] <= gidx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            sel_err   <= 1'b0;
            rr_ptr    <= '0;
        end else begin
            rd_ptr    <= rd_nx;
            wr_ptr    <= wr_ptr + AW'(grant);
            count     <= count + CW'(grant) - CW'(pop);
            out_valid <= (cnt_left != '0) || grant;
            sel_err   <= (MODE == 0) && sel_valid && sel_bad;
            // Head register: bypass the new token when it lands in an empty slot.
            if (grant && cnt_left == '0) begin
                out_data <= wtok;
                out_src  <= gidx;
            end else if (cnt_left != '0) begin
                out_data <= mem_d[rd_nx];
                out_src  <= mem_s[rd_nx];
            end
            if (MODE != 0 && grant) begin
                rr_ptr <= SEL_W'((int'(gidx) + 1) % NUM_IN);
            end
        end
    end

endmodule

// File: tb/tb_csp_mux_n.sv
// tb_csp_mux_n: directed vectors with queue scoreboards for csp_mux_n
// in controlled (2- and 3-way) and round-robin (4-way) configurations.
module tb_csp_mux_n;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [21:0] a_in_data;
    logic [1:0]  a_in_valid, a_in_ready;
    logic        a_sel, a_sel_valid, a_sel_ready;
    logic [10:0] a_out_data;
    logic        a_out_src, a_out_valid, a_out_ready, a_sel_err;
    logic [1:0]  a_count;

    logic [32:0] b_in_data;
    logic [2:0]  b_in_valid, b_in_ready;
    logic [1:0]  b_sel;
    logic        b_sel_valid, b_sel_ready;
    logic [10:0] b_out_data;
    logic [1:0]  b_out_src;
    logic        b_out_valid, b_out_ready, b_sel_err;
    logic [1:0]  b_count;

    logic [43:0] c_in_data;
    logic [3:0]  c_in_valid, c_in_ready;
    logic [1:0]  c_sel;
    logic        c_sel_valid, c_sel_ready;
    logic [10:0] c_out_data;
    logic [1:0]  c_out_src;
    logic        c_out_valid, c_out_ready, c_sel_err;
    logic [1:0]  c_count;

    csp_mux_n #(.WIDTH(11), .NUM_IN(2), .SEL_W(1), .DEPTH(2), .MODE(0)) u_a (
        .clk(clk), .reset(rst_n),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .sel_data(a_sel), .sel_valid(a_sel_valid), .sel_ready(a_sel_ready),
        .out_data(a_out_data), .out_src(a_out_src), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .sel_err(a_sel_err), .count(a_count)
    );

    csp_mux_n #(.WIDTH(11), .NUM_IN(3), .SEL_W(2), .DEPTH(2), .MODE(0)) u_b (
        .clk(clk), .reset(rst_n),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .sel_data(b_sel), .sel_valid(b_sel_valid), .sel_ready(b_sel_ready),
        .out_data(b_out_data), .out_src(b_out_src), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .sel_err(b_sel_err), .count(b_count)
    );

    csp_mux_n #(.WIDTH(11), .NUM_IN(4), .SEL_W(2), .DEPTH(2), .MODE(1)) u_c (
        .clk(clk), .reset(rst_n),
        .in_data(c_in_data), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .sel_data(c_sel), .sel_valid(c_sel_valid), .sel_ready(c_sel_ready),
        .out_data(c_out_data), .out_src(c_out_src), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .sel_err(c_sel_err), .count(c_count)
    );

    logic [15:0] qa[$];
    logic [15:0] qc[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ent(input int s, input int d);
        return {5'(s), 11'(d)};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : mon_a
        logic [15:0] e;
        if (rst_n && a_out_valid && a_out_ready) begin
            if (qa.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL a_unexpected actual=%h required=none",
                         {5'(a_out_src), a_out_data});
            end else begin
                e = qa.pop_front();
                chk("a_out", 32'({5'(a_out_src), a_out_data}), 32'(e));
            end
        end
    end

    always @(negedge clk) begin : mon_c
        logic [15:0] e;
        if (rst_n && c_out_valid && c_out_ready) begin
            if (qc.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL c_unexpected actual=%h required=none",
                         {5'(c_out_src), c_out_data});
            end else begin
                e = qc.pop_front();
                chk("c_out", 32'({5'(c_out_src), c_out_data}), 32'(e));
            end
        end
    end

    logic [3:0] rr_oh [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    int         rr_ix [5] = '{0, 1, 2, 3, 0};

    initial begin
        int acc;
        a_in_data = '0; a_in_valid = '0; a_sel = '0; a_sel_valid = 1'b0;
        a_out_ready = 1'b0;
        b_in_data = '0; b_in_valid = '0; b_sel = '0; b_sel_valid = 1'b0;
        b_out_ready = 1'b0;
        c_in_data = '0; c_in_valid = '0; c_sel = '0; c_sel_valid = 1'b0;
        c_out_ready = 1'b0;

        // reset state with valids asserted
        a_sel_valid = 1'b1;
        a_in_valid  = 2'b11;
        c_in_valid  = 4'hf;
        c_sel_valid = 1'b1;
        #12;
        chk("rst_a_in_ready", 32'(a_in_ready), 32'(0));
        chk("rst_a_sel_ready", 32'(a_sel_ready), 32'(0));
        chk("rst_a_out_valid", 32'(a_out_valid), 32'(0));
        chk("rst_a_out_data", 32'(a_out_data), 32'(0));
        chk("rst_a_count", 32'(a_count), 32'(0));
        chk("rst_a_sel_err", 32'(a_sel_err), 32'(0));
        chk("rst_c_in_ready", 32'(c_in_ready), 32'(0));
        a_sel_valid = 1'b0;
        a_in_valid  = 2'b00;
        c_in_valid  = 4'h0;
        c_sel_valid = 1'b0;
        cyc();
        rst_n = 1'b1;

        // controlled mux: sel 0,1,1
        a_out_ready = 1'b1;
        a_in_data   = {11'h2AA, 11'h155};
        a_in_valid  = 2'b11;
        a_sel       = 1'b0;
        a_sel_valid = 1'b1;
        #1;
        chk("m0_sel0_ready", 32'(a_sel_ready), 32'(1));
        chk("m0_sel0_in_ready", 32'(a_in_ready), 32'(2'b01));
        qa.push_back(ent(0, 11'h155));
        cyc();
        a_sel = 1'b1;
        #1;
        chk("m0_sel1_in_ready", 32'(a_in_ready), 32'(2'b10));
        qa.push_back(ent(1, 11'h2AA));
        cyc();
        a_in_data[21:11] = 11'h001;
        #1;
        chk("m0_sel1b_in_ready", 32'(a_in_ready), 32'(2'b10));
        qa.push_back(ent(1, 11'h001));
        cyc();
        a_sel_valid = 1'b0;
        a_in_valid  = 2'b00;

        // select waits for its data
        a_sel       = 1'b1;
        a_sel_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("wait_sel_ready", 32'(a_sel_ready), 32'(0));
            chk("wait_in_ready", 32'(a_in_ready), 32'(0));
            cyc();
        end
        a_in_data[21:11] = 11'h3C3;
        a_in_valid = 2'b10;
        #1;
        chk("wait_rise_sel_ready", 32'(a_sel_ready), 32'(1));
        chk("wait_rise_in_ready", 32'(a_in_ready), 32'(2'b10));
        qa.push_back(ent(1, 11'h3C3));
        cyc();
        a_sel_valid = 1'b0;
        a_in_valid  = 2'b00;
        repeat (3) cyc();

        // backpressure on a 2-deep FIFO
        a_out_ready = 1'b0;
        a_sel       = 1'b0;
        a_sel_valid = 1'b1;
        a_in_valid  = 2'b01;
        acc = 0;
        for (int k = 0; k < 5; k++) begin
            a_in_data[10:0] = 11'(11'h100 + k);
            #1;
            if (a_in_ready[0]) begin
                acc++;
                qa.push_back(ent(0, 11'h100 + k));
            end
            if (k >= 2) begin
                chk("bp_in_ready", 32'(a_in_ready), 32'(0));
                chk("bp_sel_ready", 32'(a_sel_ready), 32'(0));
                chk("bp_count", 32'(a_count), 32'(2));
                chk("bp_head", 32'(a_out_data), 32'(11'h100));
            end
            cyc();
        end
        chk("bp_accepts", 32'(acc), 32'(2));
        a_out_ready = 1'b1;
        a_in_data[10:0] = 11'h105;
        #1;
        chk("bp_no_passthru", 32'(a_in_ready), 32'(0));
        cyc();
        chk("bp_resume_count", 32'(a_count), 32'(1));
        chk("bp_resume_ready", 32'(a_in_ready), 32'(2'b01));
        qa.push_back(ent(0, 11'h105));
        cyc();
        a_sel_valid = 1'b0;
        a_in_valid  = 2'b00;
        repeat (4) cyc();

        // 3-way mux: out-of-range select, then a good one
        b_out_ready = 1'b1;
        b_in_data   = {11'h7FF, 11'h0F0, 11'h00F};
        b_in_valid  = 3'b111;
        b_sel       = 2'd3;
        b_sel_valid = 1'b1;
        #1;
        chk("bad_sel_ready", 32'(b_sel_ready), 32'(1));
        chk("bad_in_ready", 32'(b_in_ready), 32'(0));
        cyc();
        b_sel_valid = 1'b0;
        #1;
        chk("bad_sel_err", 32'(b_sel_err), 32'(1));
        chk("bad_count", 32'(b_count), 32'(0));
        chk("bad_out_valid", 32'(b_out_valid), 32'(0));
        cyc();
        chk("bad_sel_err_clear", 32'(b_sel_err), 32'(0));
        b_sel       = 2'd2;
        b_sel_valid = 1'b1;
        #1;
        chk("b_sel2_in_ready", 32'(b_in_ready), 32'(3'b100));
        cyc();
        b_sel_valid = 1'b0;
        b_in_valid  = 3'b000;
        #1;
        chk("b_latency_valid", 32'(b_out_valid), 32'(1));
        chk("b_out", 32'({b_out_src, b_out_data}), 32'({2'd2, 11'h7FF}));
        repeat (2) cyc();

        // round-robin with every input valid
        c_out_ready = 1'b1;
        c_in_data   = {11'h0A3, 11'h0A2, 11'h0A1, 11'h0A0};
        c_sel_valid = 1'b1;
        c_in_valid  = 4'hf;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rr_grant", 32'(c_in_ready), 32'(rr_oh[k]));
            chk("rr_sel_ready", 32'(c_sel_ready), 32'(0));
            if (k >= 1) chk("rr_count", 32'(c_count), 32'(1));
            qc.push_back(ent(rr_ix[k], 11'h0A0 + rr_ix[k]));
            cyc();
        end
        c_in_valid  = 4'h0;
        c_sel_valid = 1'b0;
        repeat (3) cyc();

        // reset in the middle of operation
        a_out_ready = 1'b0;
        a_sel       = 1'b0;
        a_sel_valid = 1'b1;
        a_in_valid  = 2'b01;
        a_in_data   = {11'h000, 11'h0EE};
        repeat (2) cyc();
        chk("mid_fill_count", 32'(a_count), 32'(2));
        a_sel_valid = 1'b0;
        a_in_valid  = 2'b00;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_out_valid", 32'(a_out_valid), 32'(0));
        chk("mid_count", 32'(a_count), 32'(0));
        cyc();
        rst_n = 1'b1;
        a_out_ready = 1'b1;
        repeat (5) cyc();
        chk("mid_no_stale", 32'(a_out_valid), 32'(0));

        chk("qa_empty", 32'(qa.size()), 32'(0));
        chk("qc_empty", 32'(qc.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/csp_mux_n.md
Name: csp_mux_n

Overview:
- Clocked, parametrised successor to the 2-way 11-bit controlled channel mux.
- Merges NUM_IN WIDTH-bit valid/ready input channels onto one output channel.
- MODE=0: each select token steers exactly one data token. MODE=1: round-robin merge with no select channel.
- Output is decoupled by a DEPTH-entry FIFO that also records the source index. Sits in the router datapath ahead of the output port buffers.

Parameters:
- WIDTH, 11, data bits per token
- NUM_IN, 2, number of input channels (2..16)
- SEL_W, 1, select/source index width; must be at least ceil(log2(NUM_IN))
- DEPTH, 2, output FIFO entries (power of two, 2..16)
- MODE, 0, 0 = controlled mux, 1 = round-robin merge

Ports:
- clk  in  1  clock, all state updates on the rising edge
- reset  in  1  asynchronous active-low reset
- in_data  in  NUM_IN*WIDTH  input tokens; channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  NUM_IN  per-channel token valid
- in_ready  out  NUM_IN  per-channel token accepted this cycle
- sel_data  in  SEL_W  select token (MODE=0)
- sel_valid  in  1  select token valid
- sel_ready  out  1  select token accepted this cycle
- out_data  out  WIDTH  head-of-FIFO token
- out_src  out  SEL_W  input index the head token came from
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts head token
- sel_err  out  1  one-cycle pulse: out-of-range select consumed
- count  out  clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset asserted (reset=0), asynchronously:
  - FIFO read pointer, write pointer and count = 0.
  - out_valid=0, out_data=0, out_src=0, sel_err=0.
  - Round-robin pointer = 0.
  - All in_ready=0 and sel_ready=0 while reset is low.
  - Tokens in flight are discarded; no partial transfer survives reset.
- Handshake: a transfer on any channel occurs on the clock edge where its valid and ready are both 1. Ready is combinational from valid and FIFO state only; there is no path from out_ready to any in_ready.
- full is count==DEPTH. An input accept requires !full; there is no pass-through push on a full FIFO even when a pop happens in the same cycle.
- MODE=0:
  - Let s = sel_data. When sel_valid=1, s<NUM_IN, in_valid[s]=1 and !full: sel_ready=1, in_ready[s]=1, and {s, token s} is pushed. Select and data are consumed atomically in the same cycle.
  - sel_valid=1 with in_valid[s]=0: nothing is consumed; the select waits. Other inputs are never granted.
  - s>=NUM_IN with sel_valid=1: the select is consumed (sel_ready=1) regardless of FIFO state, no data is consumed, and sel_err pulses on the next cycle.
- MODE=1:
  - sel_ready=0 always.
  - Grant the first i with in_valid[i]=1, searching upward from the round-robin pointer with wrap-around, when !full.
  - After a grant of i, the pointer becomes (i+1) mod NUM_IN. The pointer holds when nothing is granted.
  - At most one grant per cycle.
- FIFO:
  - Push writes at the write pointer; pop (out_valid && out_ready) advances the read pointer. Pointers wrap modulo DEPTH.
  - Simultaneous push and pop leaves count unchanged.
  - out_data and out_src are registered views of the head entry.
  - Latency: a token accepted at edge N is visible with out_valid=1 after edge N (one cycle).
  - out_data and out_src hold stable while out_valid=1 and out_ready=0.
- Throughput: one token per cycle when the FIFO is not full and out_ready=1 continuously.

Test Plan:
- Reset mid-operation:
  - Stimulus: fill the FIFO with 2 tokens, then pull reset=0 between clock edges.
  - Response: out_valid=0 and count=0 immediately; after release, no stale tokens appear.
- MODE=0, NUM_IN=2, WIDTH=11:
  - Stimulus: X=11'h155, Y=11'h2AA, sel sequence 0,1,1 (second Y token 11'h001).
  - Response: outputs 155/src0, 2AA/src1, 001/src1 in order. X is never consumed during the 1-selects.
- MODE=0, select waits for data:
  - Stimulus: sel=1 while in_valid[1]=0 for 3 cycles.
  - Response: sel_ready=0 and in_ready=00 for those 3 cycles; the token is accepted in the cycle in_valid[1] rises.
- MODE=0, NUM_IN=3, bad select:
  - Stimulus: sel=3.
  - Response: select consumed, one sel_err pulse, no push, count unchanged.
- MODE=1, NUM_IN=4, all inputs permanently valid:
  - Stimulus: all four in_valid=1 continuously, out_ready=1.
  - Response: grants rotate 0,1,2,3,0, one token per cycle.
- Backpressure, DEPTH=2:
  - Stimulus: out_ready=0 for 5 cycles.
  - Response: exactly 2 accepts, then all ready=0 with count=2 and head stable. When out_ready=1 is restored, tokens drain in order and accepts resume on the cycle after count drops to 1.
